// File: rtl/player_collider.sv
// Tile-map collision boundary generator: scans outward from the player box for nearest solid tiles.
// Optional macro COLLIDER_BORDER_EN forces the outer ring of tiles to read as solid.
module player_collider #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TILE     = 16,
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30,
  parameter int PLAYER_W = 32,
  parameter int PLAYER_H = 48
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic signed [31:0] player_X_Pos,
  input  logic signed [31:0] player_Y_Pos,
  input  logic               map_we,
  input  logic [5:0]         map_col,
  input  logic [4:0]         map_row,
  input  logic               map_solid,
  output logic signed [31:0] player_X_Min,
  output logic signed [31:0] player_X_Max,
  output logic signed [31:0] player_Y_Min,
  output logic signed [31:0] player_Y_Max,
  output logic               bounds_valid
);

  localparam int TileShift = $clog2(TILE);

  typedef enum logic [2:0] {StCapture, StLeft, StRight, StUp, StDown, StPublish} state_e;

  state_e state_q, state_d;
  logic [MAP_COLS-1:0] map_q [MAP_ROWS];
  logic [5:0] idx_q, idx_d;
  logic [5:0] c0_q, c0_d, c1_q, c1_d;
  logic [4:0] r0_q, r0_d, r1_q, r1_d;
  logic signed [31:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic signed [31:0] x_cl, y_cl;
  logic [5:0] cap_c0, cap_c1;
  logic [4:0] cap_r0, cap_r1;
  logic col_hit, row_hit;

  function automatic logic tile_at(int col, int row);
    logic s;
    s = 1'b0;
    if (col < MAP_COLS && row < MAP_ROWS) s = map_q[5'(row)][6'(col)];
`ifdef COLLIDER_BORDER_EN
    if (col == 0 || col == MAP_COLS - 1 || row == 0 || row == MAP_ROWS - 1) s = 1'b1;
`endif
    return s;
  endfunction

  always_comb begin
    x_cl = player_X_Pos;
    if (player_X_Pos < 0) x_cl = 0;
    else if (player_X_Pos > SCREEN_W - PLAYER_W) x_cl = SCREEN_W - PLAYER_W;
    y_cl = player_Y_Pos;
    if (player_Y_Pos < 0) y_cl = 0;
    else if (player_Y_Pos > SCREEN_H - PLAYER_H) y_cl = SCREEN_H - PLAYER_H;
    cap_c0 = 6'(x_cl >>> TileShift);
    cap_c1 = 6'((x_cl + PLAYER_W - 1) >>> TileShift);
    cap_r0 = 5'(y_cl >>> TileShift);
    cap_r1 = 5'((y_cl + PLAYER_H - 1) >>> TileShift);
  end

  // idx_q is a column in LEFT/RIGHT and a row in UP/DOWN; span rows/cols are checked in parallel.
  always_comb begin
    col_hit = 1'b0;
    for (int r = 0; r < MAP_ROWS; r++) begin
      if (r >= int'(r0_q) && r <= int'(r1_q) && tile_at(int'(idx_q), r)) col_hit = 1'b1;
    end
    row_hit = 1'b0;
    for (int c = 0; c < MAP_COLS; c++) begin
      if (c >= int'(c0_q) && c <= int'(c1_q) && tile_at(c, int'(idx_q))) row_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    unique case (state_q)
      StCapture: begin
        c0_d    = cap_c0;
        c1_d    = cap_c1;
        r0_d    = cap_r0;
        r1_d    = cap_r1;
        idx_d   = cap_c0 - 6'd1;
        state_d = StLeft;
      end
      StLeft: begin
        if (c0_q == 6'd0 || col_hit || idx_q == 6'd0) begin
          xmin_d  = (c0_q != 6'd0 && col_hit) ? (int'(idx_q) + 1) * TILE : 0;
          idx_d   = c1_q + 6'd1;
          state_d = StRight;
        end else begin
          idx_d = idx_q - 6'd1;
        end
      end
      StRight: begin
        if (c1_q == 6'(MAP_COLS - 1) || col_hit || idx_q == 6'(MAP_COLS - 1)) begin
          xmax_d  = (c1_q != 6'(MAP_COLS - 1) && col_hit) ? int'(idx_q) * TILE - 1 : SCREEN_W - 1;
          idx_d   = 6'(r0_q) - 6'd1;
          state_d = StUp;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StUp: begin
        if (r0_q == 5'd0 || row_hit || idx_q == 6'd0) begin
          ymin_d  = (r0_q != 5'd0 && row_hit) ? (int'(idx_q) + 1) * TILE : 0;
          idx_d   = 6'(r1_q) + 6'd1;
          state_d = StDown;
        end else begin
          idx_d = idx_q - 6'd1;
        end
      end
      StDown: begin
        if (r1_q == 5'(MAP_ROWS - 1) || row_hit || idx_q == 6'(MAP_ROWS - 1)) begin
          ymax_d  = (r1_q != 5'(MAP_ROWS - 1) && row_hit) ? int'(idx_q) * TILE - 1 : SCREEN_H - 1;
          state_d = StPublish;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StPublish: state_d = StCapture;
      default:   state_d = StCapture;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= StCapture;
      idx_q        <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      r0_q         <= '0;
      r1_q         <= '0;
      xmin_q       <= 0;
      xmax_q       <= SCREEN_W - 1;
      ymin_q       <= 0;
      ymax_q       <= SCREEN_H - 1;
      player_X_Min <= 0;
      player_X_Max <= SCREEN_W - 1;
      player_Y_Min <= 0;
      player_Y_Max <= SCREEN_H - 1;
      bounds_valid <= 1'b0;
      for (int r = 0; r < MAP_ROWS; r++) map_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      r0_q         <= r0_d;
      r1_q         <= r1_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      bounds_valid <= (state_q == StPublish);
      if (state_q == StPublish) begin
        player_X_Min <= xmin_q;
        player_X_Max <= xmax_q;
        player_Y_Min <= ymin_q;
        player_Y_Max <= ymax_q;
      end
      if (map_we && map_col < 6'(MAP_COLS) && map_row < 5'(MAP_ROWS)) begin
        map_q[map_row][map_col] <= map_solid;
      end
    end
  end

endmodule

// File: tb/tb_player_collider.sv
// Directed self-checking bench for player_collider; honours COLLIDER_BORDER_EN for expectations.
module tb_player_collider;

`ifdef COLLIDER_BORDER_EN
  localparam int EXmin = 16, EXmax = 623, EYmin = 16, EYmax = 463;
  localparam int EClXmax = 623, EClYmin = 16;
`else
  localparam int EXmin = 0, EXmax = 639, EYmin = 0, EYmax = 479;
  localparam int EClXmax = 639, EClYmin = 0;
`endif

  logic               Clk;
  logic               Reset_n;
  logic signed [31:0] player_X_Pos, player_Y_Pos;
  logic               map_we;
  logic [5:0]         map_col;
  logic [4:0]         map_row;
  logic               map_solid;
  logic signed [31:0] player_X_Min, player_X_Max, player_Y_Min, player_Y_Max;
  logic               bounds_valid;

  int n_vec = 0;
  int n_err = 0;

  player_collider dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .player_X_Pos (player_X_Pos),
    .player_Y_Pos (player_Y_Pos),
    .map_we       (map_we),
    .map_col      (map_col),
    .map_row      (map_row),
    .map_solid    (map_solid),
    .player_X_Min (player_X_Min),
    .player_X_Max (player_X_Max),
    .player_Y_Min (player_Y_Min),
    .player_Y_Max (player_Y_Max),
    .bounds_valid (bounds_valid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_bounds(input string tag, input int a, input int b, input int c,
                              input int d);
    check({tag, "_xmin"}, player_X_Min, a);
    check({tag, "_xmax"}, player_X_Max, b);
    check({tag, "_ymin"}, player_Y_Min, c);
    check({tag, "_ymax"}, player_Y_Max, d);
  endtask

  task automatic write_tile(input int c, input int r, input logic s);
    map_we    = 1'b1;
    map_col   = 6'(c);
    map_row   = 5'(r);
    map_solid = s;
    @(negedge Clk);
    map_we    = 1'b0;
  endtask

  // Returns at the negedge where bounds_valid is high; counts a timeout as a failure.
  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    @(negedge Clk);
    cycles = 1;
    while (!bounds_valid && cycles < budget) begin
      @(negedge Clk);
      cycles++;
    end
    if (!bounds_valid) check("valid_timeout", 0, 1);
  endtask

  // Second pulse comes from a scan that started after any preceding map/position change.
  task automatic settle();
    int cyc;
    wait_valid(300, cyc);
    wait_valid(300, cyc);
  endtask

  initial begin
    int cyc;
    Reset_n      = 1'b0;
    player_X_Pos = 32;
    player_Y_Pos = 416;
    map_we       = 1'b0;
    map_col      = '0;
    map_row      = '0;
    map_solid    = 1'b0;
    repeat (3) @(negedge Clk);
    check_bounds("reset", 0, 639, 0, 479);
    check("reset_valid", bounds_valid, 0);
    Reset_n = 1'b1;

    wait_valid(200, cyc);
    check_bounds("empty", EXmin, EXmax, EYmin, EYmax);
    @(negedge Clk);
    check("valid_pulse_width", bounds_valid, 0);

    write_tile(10, 26, 1'b1);
    settle();
    check("right_hit", player_X_Max, 159);
    write_tile(10, 20, 1'b1);
    settle();
    check("right_off_span", player_X_Max, 159);

    write_tile(0, 27, 1'b1);
    write_tile(3, 20, 1'b1);
    write_tile(2, 29, 1'b1);
    settle();
    check_bounds("four_hits", 16, 159, 336, 463);

    // LEFT takes 2 cycles (cols 1,0), so three edges after the pulse the FSM is scanning RIGHT.
    wait_valid(200, cyc);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    check_bounds("mid_reset", 0, 639, 0, 479);
    check("mid_reset_valid", bounds_valid, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_valid(142, cyc);
    check("relatch_latency_ok", int'(cyc <= 142), 1);
    check_bounds("after_reset", EXmin, EXmax, EYmin, EYmax);

    write_tile(0, 5, 1'b0);
    settle();
    check("clear_col0", player_X_Min, EXmin);

    player_X_Pos = -50;
    player_Y_Pos = 900;
    settle();
    check_bounds("clamp_empty", 0, EClXmax, EClYmin, 479);
    check("clamp_x_range", int'(player_X_Min >= 0 && player_X_Max <= 639), 1);
    check("clamp_y_range", int'(player_Y_Min >= 0 && player_Y_Max <= 479), 1);

    // Clamped to (0,432): cols 0..1, rows 27..29.
    write_tile(5, 28, 1'b1);
    write_tile(1, 20, 1'b1);
    settle();
    check_bounds("clamp_hits", 0, 79, 336, 479);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
